counter_serial_loader: RTL and testbench

- Parallel-to-serial writer for the team's 8-bit up/down/shift counter.
- Accepts one byte per valid/ready handshake and drives that counter's serial-load controls (DoShiftL2R/DoShiftR2L plus CounterInMSB/CounterInLSB) for WIDTH cycles.
- After the transfer, the counter holds exactly the accepted byte.
- Sits between a host/test controller and the counter; it is the write side of the counter's serial-load interface.

---
 rtl/counter_serial_loader.sv | 146 ++++++++++++++
 tb/tb_counter_serial_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_serial_loader.sv
// Serial-load writer for the 8-bit up/down/shift counter: accepts a byte per
// valid/ready handshake and shifts it in over WIDTH cycles. Optional macro: CLEAR_FIRST_EN.
module counter_serial_loader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [WIDTH-1:0] LoadData,
  input  logic             LoadDir,
  input  logic             LoadValid,
  output logic             LoadReady,
  output logic             Busy,
  output logic             Done,
  output logic             DoShiftL2R,
  output logic             DoShiftR2L,
  output logic             CounterInMSB,
  output logic             CounterInLSB,
  output logic             DoReset
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_ready_q, load_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic shift_l2r_q, shift_l2r_d;
  logic shift_r2l_q, shift_r2l_d;
  logic in_msb_q, in_msb_d;
  logic in_lsb_q, in_lsb_d;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (LoadValid) begin
          sreg_d = LoadData;
          dir_d  = LoadDir;
          cnt_d  = '0;
`ifdef CLEAR_FIRST_EN
          state_d = S_CLEAR;
`else
          state_d = S_SHIFT;
`endif
        end
      end
      S_CLEAR: state_d = S_SHIFT;
      S_SHIFT: begin
        if (cnt_q == LastBit) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          // Keep the next serial bit at the end the counter is fed from.
          sreg_d = dir_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so every port comes straight
  // from a flop yet lines up with the cycle its state is entered.
  always_comb begin
    load_ready_d = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    done_d       = (state_d == S_DONE);
    shift_r2l_d  = (state_d == S_SHIFT) && !dir_d;
    shift_l2r_d  = (state_d == S_SHIFT) && dir_d;
    in_lsb_d     = shift_r2l_d && sreg_d[WIDTH-1];
    in_msb_d     = shift_l2r_d && sreg_d[0];
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q      <= S_IDLE;
      sreg_q       <= '0;
      dir_q        <= 1'b0;
      cnt_q        <= '0;
      load_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      shift_l2r_q  <= 1'b0;
      shift_r2l_q  <= 1'b0;
      in_msb_q     <= 1'b0;
      in_lsb_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      dir_q        <= dir_d;
      cnt_q        <= cnt_d;
      load_ready_q <= load_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      shift_l2r_q  <= shift_l2r_d;
      shift_r2l_q  <= shift_r2l_d;
      in_msb_q     <= in_msb_d;
      in_lsb_q     <= in_lsb_d;
    end
  end

`ifdef CLEAR_FIRST_EN
  logic do_reset_q, do_reset_d;

  always_comb begin
    do_reset_d = (state_d == S_CLEAR);
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      do_reset_q <= 1'b0;
    end else begin
      do_reset_q <= do_reset_d;
    end
  end

  assign DoReset = do_reset_q;
`else
  assign DoReset = 1'b0;
`endif

  assign LoadReady    = load_ready_q;
  assign Busy         = busy_q;
  assign Done         = done_q;
  assign DoShiftL2R   = shift_l2r_q;
  assign DoShiftR2L   = shift_r2l_q;
  assign CounterInMSB = in_msb_q;
  assign CounterInLSB = in_lsb_q;

endmodule

// File: tb/tb_counter_serial_loader.sv
// Bench for counter_serial_loader: drives byte loads into a behavioural shift
// counter and checks every output per cycle against an arithmetic timeline.
module tb_counter_serial_loader;

  localparam int WIDTH = 8;
`ifdef CLEAR_FIRST_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif

  logic             Clock = 1'b0;
  logic             nReset = 1'b0;
  logic [WIDTH-1:0] LoadData = '0;
  logic             LoadDir = 1'b0;
  logic             LoadValid = 1'b0;
  logic             LoadReady, Busy, Done, DoShiftL2R, DoShiftR2L;
  logic             CounterInMSB, CounterInLSB, DoReset;

  int asserts = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0] ctr = 8'h5A;
  logic       preload = 1'b0;
  logic [7:0] preload_val = '0;

  counter_serial_loader #(.WIDTH(WIDTH), .CNT_W(4)) dut (
    .Clock(Clock), .nReset(nReset), .LoadData(LoadData), .LoadDir(LoadDir),
    .LoadValid(LoadValid), .LoadReady(LoadReady), .Busy(Busy), .Done(Done),
    .DoShiftL2R(DoShiftL2R), .DoShiftR2L(DoShiftR2L),
    .CounterInMSB(CounterInMSB), .CounterInLSB(CounterInLSB), .DoReset(DoReset)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  // The attached counter: L2R moves bits toward the LSB with the new bit at the MSB.
  always @(posedge Clock) begin
    if (preload)         ctr <= preload_val;
    else if (DoReset)    ctr <= 8'h00;
    else if (DoShiftR2L) ctr <= {ctr[6:0], CounterInLSB};
    else if (DoShiftL2R) ctr <= {CounterInMSB, ctr[7:1]};
  end

  always @(negedge Clock) begin
    if (nReset) begin
      asserts++;
      if ((int'(DoShiftL2R) + int'(DoShiftR2L) + int'(DoReset)) > 1) begin
        fails++;
        $display("FAIL strobe_exclusive: l2r=%b r2l=%b rst=%b, required at most one high",
                 DoShiftL2R, DoShiftR2L, DoReset);
      end
    end
  end

  function automatic logic [7:0] outs();
    return {LoadReady, Busy, Done, DoShiftL2R, DoShiftR2L, CounterInMSB, CounterInLSB, DoReset};
  endfunction

  // Called at a negedge; returns at the negedge where LoadReady is back high.
  task automatic xfer(input logic [7:0] d, input logic dir, input logic keep_valid,
                      output int hs);
    int n;
    int k;
    logic [7:0] exp_v;
    logic [7:0] got_v;
    LoadData  = d;
    LoadDir   = dir;
    LoadValid = 1'b1;
    n = 0;
    while (LoadReady !== 1'b1 && n < 40) begin
      @(negedge Clock);
      n++;
    end
    asserts++;
    if (n >= 40) begin
      fails++;
      $display("FAIL xfer_ready_timeout: LoadReady=%b after %0d cycles, required 1", LoadReady, n);
      LoadValid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc;
    @(posedge Clock);
    for (int t = 1; t <= WIDTH + 2 + OFF; t++) begin
      @(negedge Clock);
      if (t == 1) begin
        LoadData  = 8'($urandom);
        LoadDir   = ~dir;
        LoadValid = keep_valid;
      end
      k = t - 1 - OFF;
      exp_v    = '0;
      exp_v[7] = (t == WIDTH + 2 + OFF);
      exp_v[6] = (t <= WIDTH + 1 + OFF);
      exp_v[5] = (t == WIDTH + 1 + OFF);
      if (t >= 1 + OFF && t <= WIDTH + OFF) begin
        if (dir) begin
          exp_v[4] = 1'b1;
          exp_v[2] = d[k];
        end else begin
          exp_v[3] = 1'b1;
          exp_v[1] = d[WIDTH-1-k];
        end
      end
      exp_v[0] = (OFF == 1) && (t == 1);
      got_v = outs();
      asserts++;
      if (got_v !== exp_v) begin
        fails++;
        $display("FAIL xfer_outputs t=%0d data=%h dir=%b: got rdy/busy/done/l2r/r2l/msb/lsb/rst=%b required %b",
                 t, d, dir, got_v, exp_v);
      end
      if (t == WIDTH + 1 + OFF) begin
        asserts++;
        if (ctr !== d) begin
          fails++;
          $display("FAIL ctr_at_done: counter=%h required %h (dir=%b)", ctr, d, dir);
        end
      end
`ifdef CLEAR_FIRST_EN
      if (t == 2) begin
        asserts++;
        if (ctr !== 8'h00) begin
          fails++;
          $display("FAIL ctr_after_clear: counter=%h required 00", ctr);
        end
      end
`endif
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clock);
      LoadValid = 1'($urandom);
      LoadDir   = 1'($urandom);
      LoadData  = 8'($urandom);
      asserts++;
      if (outs() !== 8'h80) begin
        fails++;
        $display("FAIL reset_outputs: got %b required 10000000", outs());
      end
    end
    LoadValid = 1'b0;
    nReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      asserts++;
      if (outs() !== 8'h80) begin
        fails++;
        $display("FAIL reset_release_idle: got %b required 10000000", outs());
      end
    end
  endtask

  task automatic test_r2l();
    int hs;
    xfer(8'hA5, 1'b0, 1'b0, hs);
  endtask

  task automatic test_l2r();
    int hs;
    xfer(8'h3C, 1'b1, 1'b0, hs);
  endtask

  task automatic test_back_to_back();
    int hs1, hs2;
    xfer(8'h01, 1'b0, 1'b1, hs1);
    xfer(8'h80, 1'b1, 1'b0, hs2);
    asserts++;
    if (hs2 - hs1 !== WIDTH + 2 + OFF) begin
      fails++;
      $display("FAIL b2b_spacing: handshakes %0d cycles apart, required %0d", hs2 - hs1, WIDTH + 2 + OFF);
    end
  endtask

  task automatic test_mid_reset();
    int hs;
    LoadData  = 8'hFF;
    LoadDir   = 1'b0;
    LoadValid = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    LoadValid = 1'b0;
    repeat (3 + OFF) @(posedge Clock);
    #1 nReset = 1'b0;
    #1;
    asserts++;
    if (outs() !== 8'h80) begin
      fails++;
      $display("FAIL midreset_async: got %b required 10000000", outs());
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      asserts++;
      if (outs() !== 8'h80) begin
        fails++;
        $display("FAIL midreset_hold: got %b required 10000000", outs());
      end
    end
    nReset = 1'b1;
    @(negedge Clock);
    asserts++;
    if (outs() !== 8'h80) begin
      fails++;
      $display("FAIL midreset_no_done: got %b required 10000000", outs());
    end
    xfer(8'h00, 1'b0, 1'b0, hs);
  endtask

  task automatic test_extremes();
    int hs;
    xfer(8'h00, 1'b1, 1'b0, hs);
    xfer(8'hFF, 1'b1, 1'b0, hs);
    xfer(8'hFF, 1'b0, 1'b0, hs);
    xfer(8'h00, 1'b0, 1'b0, hs);
  endtask

  task automatic test_random();
    int hs;
    logic keep;
    for (int i = 0; i < 12; i++) begin
      keep = 1'($urandom);
      xfer(8'($urandom), 1'($urandom), keep, hs);
      if (!keep) repeat ($urandom_range(0, 2)) @(negedge Clock);
    end
    LoadValid = 1'b0;
    @(negedge Clock);
  endtask

`ifdef CLEAR_FIRST_EN
  task automatic test_clear();
    int hs;
    preload_val = 8'h77;
    preload = 1'b1;
    @(negedge Clock);
    preload = 1'b0;
    asserts++;
    if (ctr !== 8'h77) begin
      fails++;
      $display("FAIL clear_preload: counter=%h required 77", ctr);
    end
    xfer(8'h12, 1'b0, 1'b0, hs);
  endtask
`endif

  initial begin
    test_reset();
    test_r2l();
    test_l2r();
    test_back_to_back();
    test_mid_reset();
    test_extremes();
    test_random();
`ifdef CLEAR_FIRST_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
